id_issue_stage: RTL and testbench
=================================

# id_issue_stage

Registered, parametrised RV32I integer decode/issue stage. Decodes I-type ALU, R-type ALU and LUI instructions, reads operands from the register file, and holds the result in an ID/EX output register behind a valid/ready handshake. A register-busy scoreboard interlocks read-after-write hazards until writeback. It sits between the IF/ID register and the execute unit, replacing the purely combinational decoder.

## Interface
- XLEN, 32: datapath width; must be ≥32. Immediates are sign-extended to XLEN.
- RA_W, 5: register-address width; the scoreboard has 2^RA_W entries.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  IF/ID holds an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_addr  in  XLEN  PC of the instruction.
- in_instr  in  32  instruction word.
- rs1_addr, rs2_addr  out  RA_W  register-file read addresses. Combinational from in_instr; 0 when the source is unused.
- rs1_data, rs2_data  in  XLEN  register-file read data, same cycle.
- flush  in  1  kill the issued instruction and clear the scoreboard.
- wb_valid  in  1  writeback retires a register write.
- wb_rd  in  RA_W  register written at writeback.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  execute consumes the instruction.
- out_instr, out_addr  out  32, XLEN  instruction word and PC passed through.
- out_op1, out_op2  out  XLEN  operands.
- out_rd  out  RA_W  destination register.
- out_alu_op  out  4  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS=10.
- out_reg_en  out  1  destination write enable.
- illegal  out  1  registered illegal-instruction flag (see Configuration).

## Operation
- Opcode 0010011 (I-ALU):
  - op1 = rs1_data; op2 = sign-extended imm[11:0].
  - SLLI requires func7 = 0000000.
  - SRLI/SRAI require func7 = 0000000 or 0100000; op2 = shamt zero-extended.
- Opcode 0110011 (R-ALU):
  - op1 = rs1_data; op2 = rs2_data.
  - func7 = 0100000 is legal only for ADD→SUB and SRL→SRA.
  - func7 = 0000000 is legal for all func3.
  - Any other func7 is illegal.
- Opcode 0110111 (LUI):
  - op1 = 0; op2 = sign-extended {instr[31:12], 12'b0}; alu_op = PASS.
  - rs1_addr = rs2_addr = 0.
- out_reg_en = 1 only for a legal instruction with rd ≠ 0. Otherwise out_rd = 0.
- Any other encoding is illegal. An illegal instruction issues as a NOP: op1 = op2 = 0, alu_op = ADD, reg_en = 0.
- Scoreboard:
  - busy[r] is set on issue when reg_en = 1 and r = rd.
  - busy[r] is cleared on wb_valid for r = wb_rd.
  - busy[0] is always 0.
  - If issue and clear target the same register in the same cycle, set wins.
- Hazard: a used source rs is blocked when busy[rs] & !(wb_valid & wb_rd == rs). Writeback bypasses the busy check; the register file is write-through.
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Issue occurs on in_valid & in_ready. The output register loads and out_valid = 1.
- If out_ready = 1 with no issue, out_valid = 0 next cycle. Output data holds its last value.
- flush:
  - Next cycle out_valid = 0 and busy = 0 for all registers.
  - No issue occurs in a flush cycle.
  - flush is asserted only when all in-flight writers are killed.

## Timing
- Issue latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 instruction/cycle with no hazard and out_ready held high.
- Reset (asynchronous): out_valid, out_instr, out_addr, out_op1, out_op2, out_rd, out_alu_op, out_reg_en, illegal = 0; busy = 0.
- Back-pressure: while out_valid & !out_ready, all outputs hold stable and in_ready = 0.
- A stall caused by busy[rs] releases in the same cycle wb_valid names rs. The instruction issues in that cycle.
- If rst is asserted mid-stall, the pending instruction is dropped. IF/ID must re-present it.

## Configuration
- ID_ILLEGAL_TRAP_EN defined:
  - illegal is registered with issue and is 1 for an illegal instruction.
  - It holds with out_valid and clears on the next issue or consume.
- ID_ILLEGAL_TRAP_EN undefined: illegal is tied to 0. Illegal encodings are silently issued as NOPs.

## Test plan
- Issue `addi x5,x1,-1` with rs1_data = 7, out_ready = 1 → next cycle out_valid = 1, op1 = 7, op2 = 0xFFFFFFFF, rd = 5, alu_op = ADD, reg_en = 1; busy[5] = 1.
- Issue `add x6,x5,x2` while busy[5] = 1 → in_ready = 0. Assert wb_valid with wb_rd = 5 → in_ready = 1 in that cycle; issues with alu_op = ADD.
- Issue `sub x3,x1,x2` with out_ready = 0 for 3 cycles → outputs stable, in_ready = 0. On out_ready = 1 the next instruction issues the following cycle.
- Issue `lui x7,0x80000` with XLEN = 64 → op2 = 0xFFFFFFFF80000000, alu_op = PASS, rs1_addr = 0.
- Issue func7 = 0000001 on R-type → reg_en = 0; illegal = 1 with ID_ILLEGAL_TRAP_EN defined, 0 without.
- Flush with busy[5] = 1 and out_valid = 1 → next cycle out_valid = 0, busy = 0. Assert rst mid-stall → all outputs 0 immediately.

Source files
------------

// File: rtl/id_issue_stage.sv
// RV32I decode/issue stage: I-ALU, R-ALU and LUI decode, ID/EX output register, RAW scoreboard.
// Define ID_ILLEGAL_TRAP_EN to register the illegal-instruction flag; otherwise it is tied to 0.
module id_issue_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_addr,
  input  logic [31:0]     in_instr,
  output logic [RA_W-1:0] rs1_addr,
  output logic [RA_W-1:0] rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  input  logic            wb_valid,
  input  logic [RA_W-1:0] wb_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_addr,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [RA_W-1:0] out_rd,
  output logic [3:0]      out_alu_op,
  output logic            out_reg_en,
  output logic            illegal
);

  localparam int NREG = 1 << RA_W;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  logic [6:0]        opcode_s;
  logic [6:0]        func7_s;
  logic [2:0]        func3_s;
  logic [4:0]        rd_field_s;
  logic [4:0]        rs1_field_s;
  logic [4:0]        rs2_field_s;
  logic signed [11:0] imm_i_s;
  logic signed [31:0] imm_u_s;

  logic              legal_s;
  logic              use_rs1_s;
  logic              use_rs2_s;
  logic [3:0]        alu_raw_s;
  logic [XLEN-1:0]   op1_raw_s;
  logic [XLEN-1:0]   op2_raw_s;

  logic [3:0]        alu_op_s;
  logic [XLEN-1:0]   op1_s;
  logic [XLEN-1:0]   op2_s;
  logic              reg_en_s;
  logic [RA_W-1:0]   rd_s;
  logic [RA_W-1:0]   rs1_addr_s;
  logic [RA_W-1:0]   rs2_addr_s;

  logic              hazard_s;
  logic              in_ready_s;
  logic              issue_s;
  logic [NREG-1:0]   busy_r;
  logic [NREG-1:0]   set_mask_s;
  logic [NREG-1:0]   clr_mask_s;
  logic [NREG-1:0]   busy_nxt_s;

  logic              out_valid_r;
  logic [31:0]       out_instr_r;
  logic [XLEN-1:0]   out_addr_r;
  logic [XLEN-1:0]   out_op1_r;
  logic [XLEN-1:0]   out_op2_r;
  logic [RA_W-1:0]   out_rd_r;
  logic [3:0]        out_alu_op_r;
  logic              out_reg_en_r;

  // A writeback to the same register in the same cycle releases the interlock.
  function automatic logic src_blocked(input logic [NREG-1:0] busy, input logic [RA_W-1:0] rs,
                                       input logic wbv, input logic [RA_W-1:0] wbrd);
    return busy[rs] & ~(wbv & (wbrd == rs));
  endfunction

  assign opcode_s    = in_instr[6:0];
  assign rd_field_s  = in_instr[11:7];
  assign func3_s     = in_instr[14:12];
  assign rs1_field_s = in_instr[19:15];
  assign rs2_field_s = in_instr[24:20];
  assign func7_s     = in_instr[31:25];
  assign imm_i_s     = in_instr[31:20];
  assign imm_u_s     = {in_instr[31:12], 12'h000};

  // Raw decode of opcode/func3/func7 into ALU op, operand sources and legality.
  always_comb begin
    legal_s   = 1'b0;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    alu_raw_s = ALU_ADD;
    op1_raw_s = rs1_data;
    op2_raw_s = XLEN'(imm_i_s);
    case (opcode_s)
      OPC_OP_IMM: begin
        use_rs1_s = 1'b1;
        case (func3_s)
          3'b000:  begin legal_s = 1'b1; alu_raw_s = ALU_ADD;  end
          3'b010:  begin legal_s = 1'b1; alu_raw_s = ALU_SLT;  end
          3'b011:  begin legal_s = 1'b1; alu_raw_s = ALU_SLTU; end
          3'b100:  begin legal_s = 1'b1; alu_raw_s = ALU_XOR;  end
          3'b110:  begin legal_s = 1'b1; alu_raw_s = ALU_OR;   end
          3'b111:  begin legal_s = 1'b1; alu_raw_s = ALU_AND;  end
          3'b001: begin
            legal_s   = (func7_s == F7_ZERO);
            alu_raw_s = ALU_SLL;
            op2_raw_s = XLEN'(rs2_field_s);
          end
          3'b101: begin
            legal_s   = (func7_s == F7_ZERO) | (func7_s == F7_ALT);
            alu_raw_s = (func7_s == F7_ALT) ? ALU_SRA : ALU_SRL;
            op2_raw_s = XLEN'(rs2_field_s);
          end
          default: legal_s = 1'b0;
        endcase
      end
      OPC_OP: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        op2_raw_s = rs2_data;
        case (func3_s)
          3'b000: begin
            legal_s   = (func7_s == F7_ZERO) | (func7_s == F7_ALT);
            alu_raw_s = (func7_s == F7_ALT) ? ALU_SUB : ALU_ADD;
          end
          3'b101: begin
            legal_s   = (func7_s == F7_ZERO) | (func7_s == F7_ALT);
            alu_raw_s = (func7_s == F7_ALT) ? ALU_SRA : ALU_SRL;
          end
          3'b001:  begin legal_s = (func7_s == F7_ZERO); alu_raw_s = ALU_SLL;  end
          3'b010:  begin legal_s = (func7_s == F7_ZERO); alu_raw_s = ALU_SLT;  end
          3'b011:  begin legal_s = (func7_s == F7_ZERO); alu_raw_s = ALU_SLTU; end
          3'b100:  begin legal_s = (func7_s == F7_ZERO); alu_raw_s = ALU_XOR;  end
          3'b110:  begin legal_s = (func7_s == F7_ZERO); alu_raw_s = ALU_OR;   end
          3'b111:  begin legal_s = (func7_s == F7_ZERO); alu_raw_s = ALU_AND;  end
          default: legal_s = 1'b0;
        endcase
      end
      OPC_LUI: begin
        legal_s   = 1'b1;
        alu_raw_s = ALU_PASS;
        op1_raw_s = '0;
        op2_raw_s = XLEN'(imm_u_s);
      end
      default: legal_s = 1'b0;
    endcase
  end

  // Illegal encodings collapse to a NOP that reads and writes nothing.
  assign alu_op_s   = legal_s ? alu_raw_s : ALU_ADD;
  assign op1_s      = legal_s ? op1_raw_s : '0;
  assign op2_s      = legal_s ? op2_raw_s : '0;
  assign reg_en_s   = legal_s & (rd_field_s != 5'd0);
  assign rd_s       = reg_en_s ? RA_W'(rd_field_s) : '0;
  assign rs1_addr_s = (legal_s & use_rs1_s) ? RA_W'(rs1_field_s) : '0;
  assign rs2_addr_s = (legal_s & use_rs2_s) ? RA_W'(rs2_field_s) : '0;

  assign hazard_s   = src_blocked(busy_r, rs1_addr_s, wb_valid, wb_rd) |
                      src_blocked(busy_r, rs2_addr_s, wb_valid, wb_rd);
  assign in_ready_s = (~out_valid_r | out_ready) & ~hazard_s & ~flush;
  assign issue_s    = in_valid & in_ready_s;

  // Set on issue overrides a same-cycle writeback clear; x0 is never busy.
  assign set_mask_s = (issue_s & reg_en_s) ? (NREG'(1) << rd_s) : '0;
  assign clr_mask_s = wb_valid ? (NREG'(1) << wb_rd) : '0;
  assign busy_nxt_s = flush ? '0 : (((busy_r & ~clr_mask_s) | set_mask_s) & ~NREG'(1));

  // Register-busy scoreboard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // ID/EX output register with valid/ready handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_instr_r  <= 32'h0000_0000;
      out_addr_r   <= '0;
      out_op1_r    <= '0;
      out_op2_r    <= '0;
      out_rd_r     <= '0;
      out_alu_op_r <= 4'd0;
      out_reg_en_r <= 1'b0;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
    end else if (issue_s) begin
      out_valid_r  <= 1'b1;
      out_instr_r  <= in_instr;
      out_addr_r   <= in_addr;
      out_op1_r    <= op1_s;
      out_op2_r    <= op2_s;
      out_rd_r     <= rd_s;
      out_alu_op_r <= alu_op_s;
      out_reg_en_r <= reg_en_s;
    end else if (out_ready) begin
      out_valid_r  <= 1'b0;
    end
  end

`ifdef ID_ILLEGAL_TRAP_EN
  logic illegal_r;

  // Illegal flag travels with the issued instruction and drops once it leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_r <= 1'b0;
    end else if (flush) begin
      illegal_r <= 1'b0;
    end else if (issue_s) begin
      illegal_r <= ~legal_s;
    end else if (out_valid_r & out_ready) begin
      illegal_r <= 1'b0;
    end
  end

  assign illegal = illegal_r;
`else
  assign illegal = 1'b0;
`endif

  assign in_ready   = in_ready_s;
  assign rs1_addr   = rs1_addr_s;
  assign rs2_addr   = rs2_addr_s;
  assign out_valid  = out_valid_r;
  assign out_instr  = out_instr_r;
  assign out_addr   = out_addr_r;
  assign out_op1    = out_op1_r;
  assign out_op2    = out_op2_r;
  assign out_rd     = out_rd_r;
  assign out_alu_op = out_alu_op_r;
  assign out_reg_en = out_reg_en_r;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: a 32-bit instance for the main flow and a 64-bit instance for sign extension.
module tb_id_issue_stage;

`ifdef ID_ILLEGAL_TRAP_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_instr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [4:0]  out_rd;
  logic [3:0]  out_alu_op;
  logic        out_reg_en;
  logic        illegal;

  logic [63:0] in_addr_w;
  logic [63:0] rs1_data_w;
  logic [63:0] rs2_data_w;
  logic        in_ready_w;
  logic [4:0]  rs1_addr_w;
  logic [4:0]  rs2_addr_w;
  logic        out_valid_w;
  logic [31:0] out_instr_w;
  logic [63:0] out_addr_w;
  logic [63:0] out_op1_w;
  logic [63:0] out_op2_w;
  logic [4:0]  out_rd_w;
  logic [3:0]  out_alu_op_w;
  logic        out_reg_en_w;
  logic        illegal_w;

  int checks = 0;
  int errors = 0;

  assign in_addr_w  = {32'h0000_0000, in_addr};
  assign rs1_data_w = {32'h0000_0000, rs1_data};
  assign rs2_data_w = {32'h0000_0000, rs2_data};

  id_issue_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_instr(in_instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
    .out_alu_op(out_alu_op), .out_reg_en(out_reg_en), .illegal(illegal)
  );

  id_issue_stage #(.XLEN(64), .RA_W(5)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_addr(in_addr_w), .in_instr(in_instr), .rs1_addr(rs1_addr_w), .rs2_addr(rs2_addr_w),
    .rs1_data(rs1_data_w), .rs2_data(rs2_data_w), .flush(flush), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .out_valid(out_valid_w), .out_ready(out_ready), .out_instr(out_instr_w),
    .out_addr(out_addr_w), .out_op1(out_op1_w), .out_op2(out_op2_w), .out_rd(out_rd_w),
    .out_alu_op(out_alu_op_w), .out_reg_en(out_reg_en_w), .illegal(illegal_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = 32'h0; in_instr = 32'h0;
    rs1_data = 32'h0; rs2_data = 32'h0; flush = 1'b0; wb_valid = 1'b0;
    wb_rd = 5'd0; out_ready = 1'b0;
    tick(); tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_op1", 64'(out_op1), 64'd0);
    check("rst_op2", 64'(out_op2), 64'd0);
    check("rst_rd", 64'(out_rd), 64'd0);
    check("rst_regen", 64'(out_reg_en), 64'd0);
    check("rst_ill", 64'(illegal), 64'd0);
    rst = 1'b0;

    // addi x5,x1,-1
    in_valid = 1'b1; in_addr = 32'h0000_0100; in_instr = 32'hFFF0_8293;
    rs1_data = 32'd7; rs2_data = 32'd0; out_ready = 1'b1;
    #1;
    check("addi_rs1a", 64'(rs1_addr), 64'd1);
    check("addi_rs2a", 64'(rs2_addr), 64'd0);
    check("addi_rdy", 64'(in_ready), 64'd1);
    tick();
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_op1", 64'(out_op1), 64'd7);
    check("addi_op2", 64'(out_op2), 64'h0000_0000_FFFF_FFFF);
    check("addi_rd", 64'(out_rd), 64'd5);
    check("addi_alu", 64'(out_alu_op), 64'd0);
    check("addi_regen", 64'(out_reg_en), 64'd1);
    check("addi_addr", 64'(out_addr), 64'h100);
    check("addi_instr", 64'(out_instr), 64'hFFF0_8293);
    check("addi_op2_64", out_op2_w, 64'hFFFF_FFFF_FFFF_FFFF);

    // add x6,x5,x2 stalls on busy x5 until writeback of x5
    in_addr = 32'h0000_0104; in_instr = 32'h0022_8333; rs1_data = 32'd11; rs2_data = 32'd4;
    #1;
    check("raw_stall", 64'(in_ready), 64'd0);
    check("add_rs2a", 64'(rs2_addr), 64'd2);
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("hold_op1", 64'(out_op1), 64'd7);
    check("stall_rdy", 64'(in_ready), 64'd0);
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1;
    check("wb_bypass", 64'(in_ready), 64'd1);
    tick();
    wb_valid = 1'b0;
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_op1", 64'(out_op1), 64'd11);
    check("add_op2", 64'(out_op2), 64'd4);
    check("add_rd", 64'(out_rd), 64'd6);
    check("add_alu", 64'(out_alu_op), 64'd0);

    // sub x3,x1,x2 then back-pressure for 3 cycles
    in_addr = 32'h0000_0108; in_instr = 32'h4020_81B3; rs1_data = 32'd20; rs2_data = 32'd5;
    tick();
    check("sub_op1", 64'(out_op1), 64'd20);
    check("sub_op2", 64'(out_op2), 64'd5);
    check("sub_alu", 64'(out_alu_op), 64'd1);
    check("sub_rd", 64'(out_rd), 64'd3);
    out_ready = 1'b0;
    in_addr = 32'h0000_010C; in_instr = 32'h7FF0_C513; rs1_data = 32'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_rdy", 64'(in_ready), 64'd0);
      tick();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_op1", 64'(out_op1), 64'd20);
      check("bp_alu", 64'(out_alu_op), 64'd1);
      check("bp_addr", 64'(out_addr), 64'h108);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", 64'(in_ready), 64'd1);
    tick();
    check("xori_op1", 64'(out_op1), 64'd1);
    check("xori_op2", 64'(out_op2), 64'h7FF);
    check("xori_alu", 64'(out_alu_op), 64'd5);
    check("xori_rd", 64'(out_rd), 64'd10);

    // srai x8,x1,3: shamt zero-extended
    in_addr = 32'h0000_0110; in_instr = 32'h4030_D413; rs1_data = 32'h8000_0000;
    tick();
    check("srai_op1", 64'(out_op1), 64'h8000_0000);
    check("srai_op2", 64'(out_op2), 64'd3);
    check("srai_alu", 64'(out_alu_op), 64'd7);
    check("srai_rd", 64'(out_rd), 64'd8);

    // R-type with func7 = 0000001 is illegal
    in_addr = 32'h0000_0114; in_instr = 32'h0220_8233; rs1_data = 32'd3; rs2_data = 32'd4;
    tick();
    check("ill_valid", 64'(out_valid), 64'd1);
    check("ill_op1", 64'(out_op1), 64'd0);
    check("ill_op2", 64'(out_op2), 64'd0);
    check("ill_alu", 64'(out_alu_op), 64'd0);
    check("ill_regen", 64'(out_reg_en), 64'd0);
    check("ill_rd", 64'(out_rd), 64'd0);
    check("ill_flag", 64'(illegal), 64'(EXP_ILL));

    // slli with func7 = 0100000 is illegal
    in_addr = 32'h0000_0118; in_instr = 32'h4010_9493;
    tick();
    check("slli_ill_regen", 64'(out_reg_en), 64'd0);
    check("slli_ill_flag", 64'(illegal), 64'(EXP_ILL));

    // add x0,x1,x2: legal but no register write
    in_addr = 32'h0000_011C; in_instr = 32'h0020_8033;
    tick();
    check("x0_regen", 64'(out_reg_en), 64'd0);
    check("x0_rd", 64'(out_rd), 64'd0);
    check("x0_op1", 64'(out_op1), 64'd3);
    check("x0_op2", 64'(out_op2), 64'd4);
    check("x0_ill", 64'(illegal), 64'd0);

    // lui x7,0x800F8: rs1 field bits are nonzero but unused
    in_addr = 32'h0000_0120; in_instr = 32'h800F_83B7; rs1_data = 32'h55; rs2_data = 32'h66;
    #1;
    check("lui_rs1a", 64'(rs1_addr), 64'd0);
    check("lui_rs2a", 64'(rs2_addr), 64'd0);
    tick();
    check("lui_op1", 64'(out_op1), 64'd0);
    check("lui_op2", 64'(out_op2), 64'h8000_0000 | 64'h000F_8000);
    check("lui_alu", 64'(out_alu_op), 64'd10);
    check("lui_rd", 64'(out_rd), 64'd7);
    check("lui_op2_64", out_op2_w, 64'hFFFF_FFFF_800F_8000);
    check("lui_op1_64", out_op1_w, 64'd0);

    // flush while out_valid = 1 and x7 busy; add x11,x7,x0 waits behind it
    in_addr = 32'h0000_0124; in_instr = 32'h0003_85B3; out_ready = 1'b0; flush = 1'b1;
    #1;
    check("flush_rdy", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    #1;
    check("flush_busy_clr", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    check("post_flush_valid", 64'(out_valid), 64'd1);
    check("post_flush_rd", 64'(out_rd), 64'd11);

    // addi x5 issued together with writeback of x5: set wins
    in_addr = 32'h0000_0128; in_instr = 32'hFFF0_8293; rs1_data = 32'd2;
    wb_valid = 1'b1; wb_rd = 5'd5;
    tick();
    wb_valid = 1'b0;
    check("setwin_op1", 64'(out_op1), 64'd2);
    in_addr = 32'h0000_012C; in_instr = 32'h0022_8333;
    #1;
    check("setwin_stall", 64'(in_ready), 64'd0);

    // asynchronous reset in the middle of the stall
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_op1", 64'(out_op1), 64'd0);
    check("arst_op2", 64'(out_op2), 64'd0);
    check("arst_rd", 64'(out_rd), 64'd0);
    check("arst_regen", 64'(out_reg_en), 64'd0);
    check("arst_addr", 64'(out_addr), 64'd0);
    rst = 1'b0;
    #1;
    check("arst_busy_clr", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
